// File: rtl/csr_bank.sv
// csr_bank: MMIO CSR bank for a CCI-P AFU.
//   - Word 0x0000 DFH, 0x0002/0x0004 AFU UUID low/high halves.
//   - NUM_RW software-writable 64-bit control registers at RW_BASE + 2*i.
//   - NUM_RO hardware status registers at RO_BASE + 2*j, sampled in read stage 2.
//   - Reads are a fixed two-stage pipeline: request at N, response at N+2.
//   - The CCI-P c0 Rx MMIO request and c2 Tx response structs are carried as
//     flattened fields (rx_* / tx_*) so the block has no package dependency.
// Optional feature macro: CSR_ACCESS_COUNT_EN
//   Adds 32-bit read/write access counters readable as {wr_count, rd_count}
//   at RO_BASE + 2*NUM_RO; any write to that address clears both counters.
module csr_bank #(
   parameter int             NUM_RW   = 4,
   parameter int             NUM_RO   = 4,
   parameter logic [15:0]    RW_BASE  = 16'h0010,
   parameter logic [15:0]    RO_BASE  = 16'h0040,
   parameter logic [63:0]    RW_RESET = 64'h0,
   parameter logic [127:0]   AFU_UUID = 128'h0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   // c0 Rx MMIO request fields
   input  logic                   rx_mmio_rd_valid,
   input  logic                   rx_mmio_wr_valid,
   input  logic [15:0]            rx_hdr_address,
   input  logic [1:0]             rx_hdr_length,
   input  logic [8:0]             rx_hdr_tid,
   input  logic [63:0]            rx_data,
   // datapath side
   input  logic [NUM_RO*64-1:0]   status,
   output logic [NUM_RW*64-1:0]   ctrl,
   output logic [NUM_RW-1:0]      wr_strobe,
   // c2 Tx MMIO read response fields
   output logic                   tx_mmio_rd_valid,
   output logic [8:0]             tx_hdr_tid,
   output logic [63:0]            tx_data
);

   // Type 4'b0001 (AFU), EOL bit 40 set, everything else zero.
   localparam logic [63:0] DFH_VALUE = 64'h1000_0100_0000_0000;

   // Shape a full 64-bit word for the requested access size.
   // Length 0 is a 4-byte access; any other length is treated as 8 bytes.
   function automatic logic [63:0] size_read(input logic [63:0] word,
                                             input logic        odd,
                                             input logic [1:0]  len);
      logic [63:0] res;
      if (len == 2'b00) begin
         res = odd ? {32'h0, word[63:32]} : {32'h0, word[31:0]};
      end else begin
         res = word;
      end
      return res;
   endfunction

   logic [63:0]        ctrl_q [NUM_RW];
   logic [63:0]        ctrl_d [NUM_RW];
   logic [NUM_RW-1:0]  wr_strobe_q, wr_strobe_d;

   logic               rd_accept_s;
   logic               s1_valid_q, s1_valid_d;
   logic [8:0]         s1_tid_q, s1_tid_d;
   logic [15:0]        s1_addr_q, s1_addr_d;
   logic [1:0]         s1_len_q, s1_len_d;

   logic [63:0]        rd_word_s;
   logic               tx_valid_q, tx_valid_d;
   logic [8:0]         tx_tid_q, tx_tid_d;
   logic [63:0]        tx_data_q, tx_data_d;

   // A simultaneous write wins; the read in that cycle is dropped.
   always_comb begin
      rd_accept_s = rx_mmio_rd_valid & ~rx_mmio_wr_valid;
   end

   // Write decode: update the addressed RW register and raise its strobe.
   always_comb begin
      wr_strobe_d = '0;
      for (int i = 0; i < NUM_RW; i++) begin
         ctrl_d[i] = ctrl_q[i];
         if (rx_mmio_wr_valid && (rx_hdr_address[15:1] == (RW_BASE[15:1] + 15'(i)))) begin
            wr_strobe_d[i] = 1'b1;
            if (rx_hdr_length == 2'b00) begin
               if (rx_hdr_address[0]) begin
                  ctrl_d[i][63:32] = rx_data[31:0];
               end else begin
                  ctrl_d[i][31:0] = rx_data[31:0];
               end
            end else begin
               ctrl_d[i] = rx_data;
            end
         end else begin
            ctrl_d[i] = ctrl_q[i];
         end
      end
   end

   // Read stage 1: capture the accepted request.
   always_comb begin
      s1_valid_d = rd_accept_s;
      if (rd_accept_s) begin
         s1_tid_d  = rx_hdr_tid;
         s1_addr_d = rx_hdr_address;
         s1_len_d  = rx_hdr_length;
      end else begin
         s1_tid_d  = s1_tid_q;
         s1_addr_d = s1_addr_q;
         s1_len_d  = s1_len_q;
      end
   end

`ifdef CSR_ACCESS_COUNT_EN
   localparam logic [15:0] CNT_ADDR = RO_BASE + 16'(2 * NUM_RO);

   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;
   logic        cnt_clr_s;

   // Access counters: a read is counted as it leaves stage 2, so a counter
   // read reports the count before itself; a clearing write beats increments.
   always_comb begin
      cnt_clr_s = rx_mmio_wr_valid && (rx_hdr_address[15:1] == CNT_ADDR[15:1]);
      if (cnt_clr_s) begin
         rd_cnt_d = 32'h0;
         wr_cnt_d = 32'h0;
      end else begin
         rd_cnt_d = rd_cnt_q + (s1_valid_q ? 32'd1 : 32'd0);
         wr_cnt_d = wr_cnt_q + (rx_mmio_wr_valid ? 32'd1 : 32'd0);
      end
   end

   // Access counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt_q <= 32'h0;
         wr_cnt_q <= 32'h0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end
`endif

   // Read stage 2: select the word from live register and status values.
   always_comb begin
      rd_word_s = 64'h0;
      if (s1_addr_q < RW_BASE) begin
         case (s1_addr_q[15:1])
            15'd0:   rd_word_s = DFH_VALUE;
            15'd1:   rd_word_s = AFU_UUID[63:0];
            15'd2:   rd_word_s = AFU_UUID[127:64];
            default: rd_word_s = 64'h0;
         endcase
      end else begin
         for (int i = 0; i < NUM_RW; i++) begin
            rd_word_s = rd_word_s |
               ((s1_addr_q[15:1] == (RW_BASE[15:1] + 15'(i))) ? ctrl_q[i] : 64'h0);
         end
         for (int j = 0; j < NUM_RO; j++) begin
            rd_word_s = rd_word_s |
               ((s1_addr_q[15:1] == (RO_BASE[15:1] + 15'(j))) ? status[j*64 +: 64] : 64'h0);
         end
`ifdef CSR_ACCESS_COUNT_EN
         rd_word_s = rd_word_s |
            ((s1_addr_q[15:1] == CNT_ADDR[15:1]) ? {wr_cnt_q, rd_cnt_q} : 64'h0);
`endif
      end
      tx_valid_d = s1_valid_q;
      tx_tid_d   = s1_tid_q;
      tx_data_d  = size_read(rd_word_s, s1_addr_q[0], s1_len_q);
   end

   // State registers: control bank, strobes, read pipeline and response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_RW; i++) begin
            ctrl_q[i] <= RW_RESET;
         end
         wr_strobe_q <= '0;
         s1_valid_q  <= 1'b0;
         s1_tid_q    <= 9'h0;
         s1_addr_q   <= 16'h0;
         s1_len_q    <= 2'b00;
         tx_valid_q  <= 1'b0;
         tx_tid_q    <= 9'h0;
         tx_data_q   <= 64'h0;
      end else begin
         for (int i = 0; i < NUM_RW; i++) begin
            ctrl_q[i] <= ctrl_d[i];
         end
         wr_strobe_q <= wr_strobe_d;
         s1_valid_q  <= s1_valid_d;
         s1_tid_q    <= s1_tid_d;
         s1_addr_q   <= s1_addr_d;
         s1_len_q    <= s1_len_d;
         tx_valid_q  <= tx_valid_d;
         tx_tid_q    <= tx_tid_d;
         tx_data_q   <= tx_data_d;
      end
   end

   // Pack the control registers onto the flat output bus.
   always_comb begin
      ctrl = '0;
      for (int i = 0; i < NUM_RW; i++) begin
         ctrl[i*64 +: 64] = ctrl_q[i];
      end
   end

   assign wr_strobe        = wr_strobe_q;
   assign tx_mmio_rd_valid = tx_valid_q;
   assign tx_hdr_tid       = tx_tid_q;
   assign tx_data          = tx_data_q;

endmodule
